// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and width constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_ERR  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N classic-cycle Wishbone masters, the arbiter and one slave.
// slave modport: the arbiter's view. master modport: the surrounding masters and slave.
interface wb_rr_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3
) ();

    logic [N_MASTERS-1:0]          m_cyc_i;
    logic [N_MASTERS-1:0]          m_stb_i;
    logic [N_MASTERS-1:0]          m_we_i;
    logic [WB_ADR_W*N_MASTERS-1:0] m_adr_i;
    logic [WB_DAT_W*N_MASTERS-1:0] m_dat_i;
    logic [WB_SEL_W*N_MASTERS-1:0] m_sel_i;
    logic [WB_DAT_W-1:0]           m_dat_o;
    logic [N_MASTERS-1:0]          m_ack_o;
    logic [N_MASTERS-1:0]          m_err_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic                          s_we_o;
    logic [WB_ADR_W-1:0]           s_adr_o;
    logic [WB_DAT_W-1:0]           s_dat_o;
    logic [WB_SEL_W-1:0]           s_sel_o;
    logic [WB_DAT_W-1:0]           s_dat_i;
    logic                          s_ack_i;
    logic [N_MASTERS-1:0]          gnt_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               s_sel_o, gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               s_sel_o, gnt_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req searching from last+1, modulo N.
module rr_pick #(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan the N positions after last; the first hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(last) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner per cyc, fair rotation, one dead cycle between owners.
// Optional bus-timeout watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            reset,
    wb_rr_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    arb_state_t           state, state_n;
    logic [IDX_W-1:0]     owner, owner_n;
    logic [IDX_W-1:0]     last, last_n;
    logic [N_MASTERS-1:0] gnt, gnt_n;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 cyc_own, stb_own, we_own;
    logic [WB_ADR_W-1:0]  adr_own;
    logic [WB_DAT_W-1:0]  dat_own;
    logic [WB_SEL_W-1:0]  sel_own;
    logic                 timeout_hit;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req   (bus.m_cyc_i),
        .last  (last),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Select the current owner's request lines.
    always_comb begin
        cyc_own = 1'b0;
        stb_own = 1'b0;
        we_own  = 1'b0;
        adr_own = '0;
        dat_own = '0;
        sel_own = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (owner == IDX_W'(i)) begin
                cyc_own = bus.m_cyc_i[i];
                stb_own = bus.m_stb_i[i];
                we_own  = bus.m_we_i[i];
                adr_own = bus.m_adr_i[i*WB_ADR_W +: WB_ADR_W];
                dat_own = bus.m_dat_i[i*WB_DAT_W +: WB_DAT_W];
                sel_own = bus.m_sel_i[i*WB_SEL_W +: WB_SEL_W];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Count stalled strobe cycles of the owner; saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset || state != ARB_OWN || !bus.s_stb_o || bus.s_ack_i) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout_hit = bus.s_stb_o && !bus.s_ack_i && (cnt == CNT_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // State, owner, rotation pointer and registered grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= '0;
            last  <= IDX_W'(N_MASTERS - 1);
            gnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            gnt   <= gnt_n;
        end
    end

    // Next-state decode and slave/master-side output muxing.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        gnt_n       = gnt;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n         = ARB_OWN;
                    owner_n         = pick_idx;
                    last_n          = pick_idx;
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                end
            end
            ARB_OWN: begin
                bus.s_cyc_o        = cyc_own;
                bus.s_stb_o        = cyc_own && stb_own;
                bus.s_we_o         = we_own;
                bus.s_adr_o        = adr_own;
                bus.s_dat_o        = dat_own;
                bus.s_sel_o        = sel_own;
                bus.m_ack_o[owner] = bus.s_ack_i;
                if (!cyc_own) begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                end else if (timeout_hit) begin
                    bus.m_err_o[owner] = 1'b1;
                    state_n            = ARB_ERR;
                end
            end
            ARB_ERR: begin
                if (!cyc_own) begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                end
            end
            default: begin
                state_n = ARB_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign bus.gnt_o   = gnt;
    assign bus.m_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (3 masters, TIMEOUT = 4).
module tb_wb_rr_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wb_rr_arbiter_if #(.N_MASTERS(3)) bus ();

    wb_rr_arbiter #(.N_MASTERS(3), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel);
        bus.m_cyc_i[k]          = cyc;
        bus.m_stb_i[k]          = stb;
        bus.m_we_i[k]           = we;
        bus.m_adr_i[k*32 +: 32] = adr;
        bus.m_dat_i[k*32 +: 32] = dat;
        bus.m_sel_i[k*4 +: 4]   = sel;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.gnt_o !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt_o);
        end
        checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_slave got cyc=%b stb=%b adr=%h exp 0", bus.s_cyc_o, bus.s_stb_o,
                     bus.s_adr_o);
        end
        checks++;
        if (bus.m_ack_o !== 3'b000 || bus.m_err_o !== 3'b000) begin
            failures++;
            $display("FAIL reset_ack_err got ack=%b err=%b exp 000", bus.m_ack_o, bus.m_err_o);
        end
        bus.s_dat_i = 32'hCAFE_0001;
        #1;
        checks++;
        if (bus.m_dat_o !== 32'hCAFE_0001) begin
            failures++; $display("FAIL dat_bcast got=%h exp=cafe0001", bus.m_dat_o);
        end
    endtask

    task automatic test_two_requests();
        apply_reset();
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 32'hAAAA_0000, 4'hF);
        set_master(2, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'hBBBB_0002, 4'h3);
        tick();
        checks++;
        if (bus.gnt_o !== 3'b001) begin
            failures++; $display("FAIL two_req_first_gnt got=%b exp=001", bus.gnt_o);
        end
        checks++;
        if (bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 32'h1000_0000 || bus.s_we_o !== 1'b1 ||
            bus.s_dat_o !== 32'hAAAA_0000 || bus.s_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL two_req_mux got cyc=%b adr=%h we=%b dat=%h sel=%h", bus.s_cyc_o,
                     bus.s_adr_o, bus.s_we_o, bus.s_dat_o, bus.s_sel_o);
        end
        bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.m_ack_o !== 3'b001) begin
            failures++; $display("FAIL two_req_ack got=%b exp=001", bus.m_ack_o);
        end
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        #1;
        checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL two_req_drop got cyc=%b stb=%b exp 0 0", bus.s_cyc_o, bus.s_stb_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL two_req_idle got gnt=%b cyc=%b exp 000 0", bus.gnt_o, bus.s_cyc_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 3'b100 || bus.s_adr_o !== 32'h2000_0008) begin
            failures++;
            $display("FAIL two_req_second got gnt=%b adr=%h exp 100 20000008", bus.gnt_o,
                     bus.s_adr_o);
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        logic [2:0] exp_gnt;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            set_master(k, 1'b1, 1'b1, 1'b0, 32'h100 * (k + 1), 32'h0, 4'hF);
        end
        tick();
        for (int t = 0; t < 4; t++) begin
            exp_gnt = 3'b000;
            exp_gnt[order[t]] = 1'b1;
            checks++;
            if (bus.gnt_o !== exp_gnt) begin
                failures++; $display("FAIL rr_gnt_%0d got=%b exp=%b", t, bus.gnt_o, exp_gnt);
            end
            bus.s_ack_i = 1'b1;
            #1;
            checks++;
            if (bus.m_ack_o !== exp_gnt) begin
                failures++; $display("FAIL rr_ack_%0d got=%b exp=%b", t, bus.m_ack_o, exp_gnt);
            end
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i[order[t]] = 1'b0;
            tick();
            checks++;
            if (bus.gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL rr_idle_%0d got gnt=%b cyc=%b exp 000 0", t, bus.gnt_o,
                         bus.s_cyc_o);
            end
            bus.m_cyc_i[order[t]] = 1'b1;
            tick();
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
    endtask

    task automatic test_no_preempt();
        apply_reset();
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        checks++;
        if (bus.gnt_o !== 3'b010) begin
            failures++; $display("FAIL np_gnt got=%b exp=010", bus.gnt_o);
        end
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.m_ack_o !== 3'b010 || bus.m_err_o !== 3'b000) begin
            failures++;
            $display("FAIL np_ack got ack=%b err=%b exp 010 000", bus.m_ack_o, bus.m_err_o);
        end
        tick();
        bus.s_ack_i = 1'b0;
        tick();
        checks++;
        if (bus.gnt_o !== 3'b010 || bus.s_adr_o !== 32'h0000_0040) begin
            failures++;
            $display("FAIL np_hold got gnt=%b adr=%h exp 010 00000040", bus.gnt_o, bus.s_adr_o);
        end
        bus.m_cyc_i[1] = 1'b0;
        tick();
        checks++;
        if (bus.gnt_o !== 3'b000) begin
            failures++; $display("FAIL np_idle got=%b exp=000", bus.gnt_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 3'b001 || bus.s_adr_o !== 32'h0000_0080) begin
            failures++;
            $display("FAIL np_m0 got gnt=%b adr=%h exp 001 00000080", bus.gnt_o, bus.s_adr_o);
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [2:0] exp_err;
        apply_reset();
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();
        for (int c = 1; c <= 5; c++) begin
            exp_err = (c == 5) ? 3'b001 : 3'b000;
            checks++;
            if (bus.m_err_o !== exp_err) begin
                failures++; $display("FAIL to_err_c%0d got=%b exp=%b", c, bus.m_err_o, exp_err);
            end
            tick();
        end
        checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.m_err_o !== 3'b000 ||
            bus.gnt_o !== 3'b001) begin
            failures++;
            $display("FAIL to_errstate got cyc=%b stb=%b err=%b gnt=%b exp 0 0 000 001",
                     bus.s_cyc_o, bus.s_stb_o, bus.m_err_o, bus.gnt_o);
        end
        bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.m_ack_o !== 3'b000) begin
            failures++; $display("FAIL to_ack_ignored got=%b exp=000", bus.m_ack_o);
        end
        bus.s_ack_i = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.gnt_o !== 3'b001) begin
            failures++;
            $display("FAIL to_stay_err got cyc=%b gnt=%b exp 0 001", bus.s_cyc_o, bus.gnt_o);
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        tick();
        checks++;
        if (bus.gnt_o !== 3'b000) begin
            failures++; $display("FAIL to_release got=%b exp=000", bus.gnt_o);
        end
    endtask
`else
    task automatic test_stall_no_timeout();
        int err_seen;
        apply_reset();
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();
        err_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.m_err_o !== 3'b000) err_seen++;
            tick();
        end
        checks++;
        if (err_seen != 0) begin
            failures++; $display("FAIL stall_err got=%0d err cycles exp=0", err_seen);
        end
        checks++;
        if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.gnt_o !== 3'b001) begin
            failures++;
            $display("FAIL stall_hold got cyc=%b stb=%b gnt=%b exp 1 1 001", bus.s_cyc_o,
                     bus.s_stb_o, bus.gnt_o);
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        set_master(2, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hC);
        tick();
        checks++;
        if (bus.gnt_o !== 3'b100 || bus.s_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rm_own got gnt=%b cyc=%b exp 100 1", bus.gnt_o, bus.s_cyc_o);
        end
        bus.s_ack_i = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 ||
            bus.s_we_o !== 1'b0 || bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0 ||
            bus.s_sel_o !== 4'h0 || bus.m_ack_o !== 3'b000 || bus.m_err_o !== 3'b000) begin
            failures++;
            $display("FAIL rm_cleared got gnt=%b cyc=%b stb=%b adr=%h ack=%b err=%b",
                     bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.m_ack_o, bus.m_err_o);
        end
        bus.s_ack_i = 1'b0;
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        tick();
        checks++;
        if (bus.gnt_o !== 3'b010 || bus.s_adr_o !== 32'h0000_0300) begin
            failures++;
            $display("FAIL rm_m1 got gnt=%b adr=%h exp 010 00000300", bus.gnt_o, bus.s_adr_o);
        end
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        test_reset();
        test_two_requests();
        test_round_robin();
        test_no_preempt();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_stall_no_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
